// File: rtl/cpu_pkg.sv
// Shared CPU-side types and register-file geometry used by the register file
// and by the debug dump engine that sweeps it.
package cpu_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dump_state_t;

endpackage

// File: rtl/cpu_regfile.sv
// Two-read / one-write register file with x0 hardwired to zero and
// write-to-read bypass on both read ports.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [ADDR_WIDTH-1:0] ra1,
    output logic [DATA_WIDTH-1:0] rd1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem_q[wa] <= wd;
        end
    end

    // ra==0 is checked first, so a write to x0 is never bypassed.
    assign rd1 = (ra1 == '0) ? '0 : ((we && (wa == ra1)) ? wd : mem_q[ra1]);
    assign rd2 = (ra2 == '0) ? '0 : ((we && (wa == ra2)) ? wd : mem_q[ra2]);

endmodule

// File: rtl/reg_dump.sv
// Sweeps every register-file index in ascending order through a one-entry
// valid/ready output register, then pulses done once the last word is taken.
//
// state | meaning
// IDLE  | waiting for start; ra parked at 0
// RUN   | ra = ptr; a word is loaded whenever the output slot is free or being taken
// DRAIN | last word loaded; waiting for it to be accepted
module reg_dump
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] ra,
    input  logic [DATA_WIDTH-1:0] rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

    dump_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  done_q, done_d;
    logic                  load;

    // The slot may be refilled on the same edge its current word is taken.
    assign load = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            ptr_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        ptr_d   = '0;
                    end
                end
                RUN: begin
                    if (load) begin
                        out_data_d  = rd;
                        out_addr_d  = ptr_q;
                        out_valid_d = 1'b1;
                        if (ptr_q != LAST_PTR) begin
                            ptr_d = ptr_q + 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        ptr_d       = '0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign ra        = (state_q == RUN) ? ptr_q : '0;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump sweeping the CPU register file through read port 2.
module tb_reg_dump;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start, abort, out_ready;
    logic          we;
    logic [AW-1:0] wa, ra, ra1, out_addr;
    logic [DW-1:0] wd, rd, rd1, out_data;
    logic          out_valid, busy, done;

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    logic [DW-1:0] model_rf [N];

    always #5 clk = ~clk;

    cpu_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_rf (
        .clk(clk), .rstn(rstn), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .rd1(rd1), .ra2(ra), .rd2(rd)
    );

    reg_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int i, input logic [DW-1:0] v);
        if (i != 0) model_rf[i] = v;
    endtask

    task automatic push_expected();
        for (int i = 0; i < N; i++) begin
            exp_t e;
            e.a = AW'(i);
            e.d = model_rf[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic preload(input bit rand_data);
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] v;
            v  = rand_data ? DW'($urandom) : (32'hA000_0000 + 32'(i));
            we = 1'b1;
            wa = AW'(i);
            wd = v;
            model_write(i, v);
            tick();
        end
        we = 1'b0;
    endtask

    // Scoreboard monitor: pops one expectation per accepted word.
    initial begin
        logic          stalled;
        logic [AW-1:0] held_a;
        logic [DW-1:0] held_d;
        stalled = 1'b0;
        held_a  = '0;
        held_d  = '0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                if (done === 1'b1) begin
                    done_cnt++;
                    check("done_excl_valid", 64'(out_valid), 64'(0));
                end
                if (stalled && out_valid === 1'b1) begin
                    check("stall_addr", 64'(out_addr), 64'(held_a));
                    check("stall_data", 64'(out_data), 64'(held_d));
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_word: got addr %0d, expected no word", out_addr);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("word_addr", 64'(out_addr), 64'(e.a));
                        check("word_data", 64'(out_data), 64'(e.d));
                    end
                end
                stalled = (out_valid === 1'b1) && (out_ready !== 1'b1);
                held_a  = out_addr;
                held_d  = out_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // mode: 0 ready always high, 1 ready pattern 1,0,0, 2 random ready
    task automatic run_dump(input int mode, input bit chk_lat, input bit bypass,
                            input bit start_pulses, input bit pre_started);
        int cyc_n, first_v, done_at, dc0;
        dc0     = done_cnt;
        first_v = -1;
        done_at = -1;
        out_ready = 1'b1;
        if (!pre_started) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        cyc_n = 1;
        check("busy_after_start", 64'(busy), 64'(1));
        while (done_at < 0 && cyc_n < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc_n % 3 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (bypass) begin
                if (cyc_n == 6) begin
                    we = 1'b1;
                    wa = AW'(5);
                    wd = 32'hDEAD_BEEF;
                    check("bypass_ra", 64'(ra), 64'(5));
                end else begin
                    we = 1'b0;
                end
            end
            if (start_pulses) start = (cyc_n == 10 || cyc_n == 20 || cyc_n == 33);
            tick();
            cyc_n++;
            if (out_valid === 1'b1 && first_v < 0) first_v = cyc_n;
            if (done === 1'b1) done_at = cyc_n;
        end
        we    = 1'b0;
        start = 1'b0;
        if (done_at < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc_n);
        end else begin
            check("done_busy_low", 64'(busy), 64'(0));
            if (chk_lat) begin
                check("first_valid_cycle", 64'(first_v), 64'(2));
                check("done_cycle", 64'(done_at), 64'(34));
            end
            tick();
            check("done_one_cycle", 64'(done), 64'(0));
            check("done_count", 64'(done_cnt), 64'(dc0 + 1));
            check("words_remaining", 64'(exp_q.size()), 64'(0));
        end
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int dc0;
        bit hit;
        for (int i = 0; i < N; i++) model_rf[i] = '0;
        rstn = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        we = 1'b0; wa = '0; wd = '0; ra1 = '0;
        #2 rstn = 1'b0;
        #1;
        check("rst_ra", 64'(ra), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_addr", 64'(out_addr), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Fixed preload, free-flowing consumer
        preload(1'b0);
        ra1 = AW'(7);
        #1 check("rf_port1_read", 64'(rd1), 64'(32'hA000_0007));
        ra1 = '0;
        #1 check("rf_x0_read", 64'(rd1), 64'(0));
        tick();
        push_expected();
        run_dump(0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stalling consumer 1,0,0,...
        push_expected();
        run_dump(1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write to index 5 in the cycle it is captured
        model_write(5, 32'hDEAD_BEEF);
        push_expected();
        run_dump(0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Random data, random backpressure
        preload(1'b1);
        push_expected();
        run_dump(2, 1'b0, 1'b0, 1'b0, 1'b0);

        // start and abort on the same edge
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'(0));
        tick();
        check("start_abort_valid", 64'(out_valid), 64'(0));

        // Abort while word 10 is presented
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cnt++;
            hit = (out_valid === 1'b1) && (out_addr === AW'(10));
        end
        check("abort_reach_word10", 64'(hit), 64'(1));
        out_ready = 1'b0;
        abort = 1'b1;
        dc0 = done_cnt;
        tick();
        abort = 1'b0;
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        exp_q.delete();
        tick();
        tick();
        check("abort_no_done", 64'(done_cnt), 64'(dc0));
        push_expected();
        run_dump(0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-dump at ptr 20
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cnt++;
            hit = (ra === AW'(20));
        end
        check("reset_reach_ptr20", 64'(hit), 64'(1));
        #2 rstn = 1'b0;
        #1;
        check("midrst_ra", 64'(ra), 64'(0));
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_addr", 64'(out_addr), 64'(0));
        check("midrst_data", 64'(out_data), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        exp_q.delete();
        for (int i = 0; i < N; i++) model_rf[i] = '0;
        dc0 = done_cnt;
        tick();
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("midrst_no_done", 64'(done_cnt), 64'(dc0));
        // Start on the first edge after release; extra start pulses must be ignored
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_dump(0, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 5, meaning the register-file address width; it sets the dump length to 2^ADDR_WIDTH words.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning the register-file data width.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rstn  input  1  is the reset; reset SHALL be asynchronous and active-low.
REQ-005 Port start  input  1  SHALL request a dump when sampled high in IDLE.
REQ-006 Port abort  input  1  SHALL be a synchronous cancel, effective in any state.
REQ-007 Port ra  output  ADDR_WIDTH  SHALL drive the address of one register-file read port.
REQ-008 Port rd  input  DATA_WIDTH  SHALL carry the combinational read data for ra, including write-bypassed data.
REQ-009 Port out_valid  output  1  SHALL be high when out_addr and out_data hold a word.
REQ-010 Port out_ready  input  1  SHALL be the consumer's acceptance signal.
REQ-011 Port out_addr  output  ADDR_WIDTH  SHALL give the register index of out_data.
REQ-012 Port out_data  output  DATA_WIDTH  SHALL give the captured register value.
REQ-013 Port busy  output  1  SHALL be high whenever state is not IDLE.
REQ-014 Port done  output  1  SHALL be a one-cycle pulse after the last word is accepted.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and DRAIN.
REQ-016 In IDLE, start=1 SHALL move the FSM to RUN with ptr=0; start SHALL be ignored in RUN and DRAIN.
REQ-017 ra SHALL equal ptr in RUN and SHALL be 0 in IDLE and DRAIN.
REQ-018 Load condition L = !out_valid || out_ready; a word accepted on the same edge as a new load SHALL therefore not stall the sweep.
REQ-019 In RUN with L=1, the module SHALL register out_data<=rd, out_addr<=ptr and out_valid<=1; if ptr < 2^ADDR_WIDTH-1 it SHALL also set ptr<=ptr+1, otherwise it SHALL move to DRAIN.
REQ-020 In RUN with L=0, ptr, out_addr and out_data SHALL hold.
REQ-021 ptr SHALL never wrap, and every index 0..2^ADDR_WIDTH-1 SHALL be emitted exactly once, in ascending order.
REQ-022 In DRAIN, out_valid&&out_ready SHALL clear out_valid, assert done on the following cycle, and return the FSM to IDLE; busy SHALL be low in the done cycle.
REQ-023 Any other handshake (out_valid&&out_ready in RUN) SHALL only consume the word, per REQ-018.
REQ-024 While out_valid=1 and out_ready=0, out_addr and out_data SHALL be stable.
REQ-025 A captured word SHALL be the value of rd in the cycle it is loaded, so a same-cycle register-file write to that index SHALL be reflected through the bypass.
REQ-026 Latency with out_ready held at 1: start sampled at edge 0; RUN in cycles 1..32; word k valid in cycle k+2; the last word is valid in cycle 33; done is high in cycle 34.
REQ-027 abort=1 SHALL have priority over start and over handshakes: it SHALL return the FSM to IDLE, clear out_valid and ptr, and SHALL NOT pulse done.
REQ-028 A start and an abort sampled on the same edge SHALL leave the FSM in IDLE.
REQ-029 done SHALL never be high together with out_valid.

Reset
REQ-030 While rstn=0, the module SHALL immediately force: state=IDLE, ptr=0, ra=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
REQ-031 Reset asserted mid-dump SHALL discard the dump; no done pulse SHALL follow.
REQ-032 Deassertion of rstn SHALL take effect at a clk edge, and the first start SHALL be accepted on the first edge after deassertion.

Structure
REQ-033 The state enum dump_state_t {IDLE, RUN, DRAIN} SHALL live in the shared package cpu_pkg.
REQ-034 ADDR_WIDTH and DATA_WIDTH SHALL remain module parameters, matching the register file's parameters.
REQ-035 The module SHALL be a single module with no sub-module: the one-entry output register and the FSM are too small to split.
REQ-036 The bench SHALL instance the existing register file with reg_dump driving its read port 2.

Verification
REQ-037 Preload rf[i]=32'hA000_0000+i, set out_ready=1, pulse start -> 32 words with out_addr 0..31 and matching data, done in cycle 34, word 0 = 0.
REQ-038 Same preload with out_ready toggling 1,0,0,1,... -> no word lost or duplicated, data stable while stalled, ascending order.
REQ-039 Write rf[5]<=32'hDEAD_BEEF in the cycle ptr=5 is loaded -> out_data for addr 5 = 32'hDEAD_BEEF.
REQ-040 Assert abort while out_addr=10 and out_valid=1 -> next cycle out_valid=0, busy=0, no done; a following start restarts at addr 0.
REQ-041 Drop rstn while ptr=20 -> outputs zero immediately, no done; pulse start while busy -> ignored, count stays 32.
